// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver (configurable divider, data width, parity, stop bits) with
//   glitch rejection on the start bit, sticky error flags and a
//   first-word-fall-through output FIFO.
//
// Parameters
//   CLK_DIV    clk cycles per bit (even, >= 4)
//   DATA_BITS  data bits per character (5..9)
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//   FIFO_DEPTH FIFO entries (power of two, >= 2)
//
// Ports
//   clk         single clock, everything on posedge
//   reset       synchronous, active-high
//   rx          asynchronous serial input, idle high
//   rd_en       pop the head entry (ignored while rd_valid=0)
//   rd_data     FIFO head, valid while rd_valid=1 (0 when empty)
//   rd_valid    FIFO not empty
//   fifo_count  FIFO occupancy, 0..FIFO_DEPTH
//   err_clr     clears the sticky error flags
//   frame_err   sticky: a stop bit was sampled low
//   parity_err  sticky: a parity mismatch occurred
//   overrun     sticky: a character was dropped because the FIFO was full
//   busy        receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLK_DIV    = 20,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   input  logic                          err_clr,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] HALF_M1   = CW'(CLK_DIV/2 - 1);
   localparam logic [CW-1:0] FULL_M1   = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_V   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // ------------------------------------------------------------------
   // rx synchroniser; r_rxs is the only copy of the line the FSM sees
   // ------------------------------------------------------------------
   logic r_sync1;
   logic r_rxs;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rxs   <= r_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;
   logic                 r_busy;

   logic w_sample;
   logic w_par_exp;
   logic w_stop_tick;
   logic w_frame_ev;
   logic w_last_stop;
   logic w_par_ev;
   logic w_push;

   assign w_sample  = (r_cnt == FULL_M1);
   // Even parity: the parity bit equals XOR of data; odd: its complement.
   assign w_par_exp = (PARITY == 2) ? ^r_shift : ~^r_shift;

   // Character outcome is decided on the stop-bit sample itself so the
   // push lands in the FIFO at that same edge.
   assign w_stop_tick = (r_state == S_STOP) && w_sample;
   assign w_frame_ev  = w_stop_tick && !r_rxs;
   assign w_last_stop = w_stop_tick && r_rxs && (r_stop_idx == STOP_LAST);
   assign w_par_ev    = w_last_stop && r_par_bad;
   assign w_push      = w_last_stop && !r_par_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par_bad  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_rxs) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end

            // Re-check the line at mid start bit; high there means the
            // falling edge was a glitch.
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt <= '0;
                  if (r_rxs) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                     r_par_bad <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (w_sample) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};  // LSB first
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == LAST_BIT) begin
                     r_stop_idx <= 1'b0;
                     r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (w_sample) begin
                  r_cnt     <= '0;
                  r_par_bad <= (r_rxs != w_par_exp);
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (w_sample) begin
                  r_cnt <= '0;
                  if (!r_rxs) begin
                     r_state <= S_WAIT_IDLE;
                  end else if (r_stop_idx == STOP_LAST) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_stop_idx <= r_stop_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            // Line held low (break): wait for it to return high before
            // hunting for the next start bit.
            S_WAIT_IDLE: begin
               if (r_rxs) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;

   // ------------------------------------------------------------------
   // FWFT FIFO
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;

   logic w_pop;
   logic w_full;
   logic w_wr;
   logic w_ovr_ev;

   assign w_pop    = rd_en && (r_count != '0);
   assign w_full   = (r_count == DEPTH_V);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_wr     = w_push && (!w_full || w_pop);
   assign w_ovr_ev = w_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr && !reset) begin
         r_mem[r_wr_ptr] <= r_shift;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_valid   = (r_count != '0);
   assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
   assign fifo_count = r_count;

   // ------------------------------------------------------------------
   // Sticky error flags; a new event beats a simultaneous clear.
   // ------------------------------------------------------------------
   logic r_frame_err;
   logic r_parity_err;
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_err  <= (r_frame_err  && !err_clr) || w_frame_ev;
         r_parity_err <= (r_parity_err && !err_clr) || w_par_ev;
         r_overrun    <= (r_overrun    && !err_clr) || w_ovr_ev;
      end
   end

   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign overrun    = r_overrun;

endmodule
